// File: rtl/load_issue_unit_pkg.sv
// Shared payload types for the load issue path.
//   load_rs_entry_t : one load reservation-station entry (state, addr, funct3, pd, rob_num)
//   cdb_t           : common data bus broadcast (valid, pd, rob_num, value)
package load_issue_unit_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned PHYS_REG_BITS = 6;
  localparam int unsigned ROB_BITS      = 5;

  typedef enum logic [1:0] {
    RS_EMPTY = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2
  } rs_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    rs_state_e                state;
    logic [XLEN-1:0]          addr;
    logic [2:0]               funct3;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_BITS-1:0]      rob_num;
  } load_rs_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_BITS-1:0]      rob_num;
    logic [XLEN-1:0]          value;
  } cdb_t;

endpackage

// File: rtl/load_issue_unit.sv
// load_issue_unit: consumer side of the load reservation station.
// Picks one READY load per idle cycle, releases its entry (free/free_idx),
// issues a single outstanding data-memory read, then aligns/extends the
// returned word and broadcasts it on the load CDB. One load in flight.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mispredict        flush: no capture, in-flight result discarded
//   rs_entries        station entry array (scanned in IDLE)
//   free, free_idx    combinational release pulse for the captured entry
//   dmem_addr/rmask   word-aligned read address and byte mask (registered)
//   dmem_read         request valid, held until dmem_resp
//   dmem_resp/rdata   one-cycle response and data word
//   load_cdb          result broadcast; valid gated by mispredict
//
// Build option: define LOAD_ISSUE_ROUND_ROBIN_EN for a rotating scan start
// (rr_ptr); otherwise the lowest READY index wins.
module load_issue_unit
  import load_issue_unit_pkg::*;
#(
  parameter int unsigned NUM_LOAD_RS  = 8,
  parameter int unsigned LOAD_RS_BITS = $clog2(NUM_LOAD_RS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mispredict,
  input  load_rs_entry_t          rs_entries [NUM_LOAD_RS],
  output logic                    free,
  output logic [LOAD_RS_BITS-1:0] free_idx,
  output logic [31:0]             dmem_addr,
  output logic [3:0]              dmem_rmask,
  output logic                    dmem_read,
  input  logic                    dmem_resp,
  input  logic [31:0]             dmem_rdata,
  output cdb_t                    load_cdb
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BCAST = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     dmem_read_q, dmem_read_d;
  logic [31:0]              dmem_addr_q, dmem_addr_d;
  logic [3:0]               dmem_rmask_q, dmem_rmask_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [1:0]               off_q, off_d;
  logic [PHYS_REG_BITS-1:0] pd_q, pd_d;
  logic [ROB_BITS-1:0]      rob_q, rob_d;
  cdb_t                     cdb_q, cdb_d;

  logic                     sel_found;
  logic [LOAD_RS_BITS-1:0]  sel_idx;

  // Byte mask for a load of the given width at byte offset off.
  function automatic logic [3:0] rmask_for(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: rmask_for = 4'b0001 << off;
      F3_LH, F3_LHU: rmask_for = 4'b0011 << off;
      default:       rmask_for = 4'b1111;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] align_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      F3_LB:   align_load = {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  align_load = {24'd0, sh[7:0]};
      F3_LH:   align_load = {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  align_load = {16'd0, sh[15:0]};
      default: align_load = rdata;
    endcase
  endfunction

`ifdef LOAD_ISSUE_ROUND_ROBIN_EN
  logic [LOAD_RS_BITS-1:0] rr_ptr_q, rr_ptr_d;
  int unsigned             scan_idx;

  // First READY entry at or after rr_ptr, wrapping around the array.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NUM_LOAD_RS; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % NUM_LOAD_RS;
      if (!sel_found && rs_entries[LOAD_RS_BITS'(scan_idx)].state == RS_READY) begin
        sel_found = 1'b1;
        sel_idx   = LOAD_RS_BITS'(scan_idx);
      end
    end
  end
`else
  // Fixed priority: lowest READY index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_LOAD_RS; k++) begin
      if (!sel_found && rs_entries[LOAD_RS_BITS'(k)].state == RS_READY) begin
        sel_found = 1'b1;
        sel_idx   = LOAD_RS_BITS'(k);
      end
    end
  end
`endif

  // Next-state, capture and response handling.
  always_comb begin
    state_d      = state_q;
    dmem_read_d  = dmem_read_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_rmask_d = dmem_rmask_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    pd_d         = pd_q;
    rob_d        = rob_q;
    cdb_d        = cdb_q;
    cdb_d.valid  = 1'b0;
    free         = 1'b0;
    free_idx     = '0;
`ifdef LOAD_ISSUE_ROUND_ROBIN_EN
    rr_ptr_d     = rr_ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (sel_found && !mispredict) begin
          free         = 1'b1;
          free_idx     = sel_idx;
          dmem_addr_d  = {rs_entries[sel_idx].addr[31:2], 2'b00};
          dmem_rmask_d = rmask_for(rs_entries[sel_idx].funct3, rs_entries[sel_idx].addr[1:0]);
          funct3_d     = rs_entries[sel_idx].funct3;
          off_d        = rs_entries[sel_idx].addr[1:0];
          pd_d         = rs_entries[sel_idx].pd;
          rob_d        = rs_entries[sel_idx].rob_num;
          dmem_read_d  = 1'b1;
          state_d      = S_REQ;
`ifdef LOAD_ISSUE_ROUND_ROBIN_EN
          rr_ptr_d     = (32'(sel_idx) == NUM_LOAD_RS - 1) ? '0 : sel_idx + LOAD_RS_BITS'(1);
`endif
        end
      end
      S_REQ: begin
        if (dmem_resp) begin
          // A flush landing on the response cycle still spends the BCAST
          // cycle but never raises valid.
          dmem_read_d   = 1'b0;
          state_d       = S_BCAST;
          cdb_d.valid   = !mispredict;
          cdb_d.pd      = pd_q;
          cdb_d.rob_num = rob_q;
          cdb_d.value   = align_load(funct3_q, off_q, dmem_rdata);
        end else if (mispredict) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Request stays up until the memory answers; the data is dropped.
        if (dmem_resp) begin
          dmem_read_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_BCAST: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dmem_read_q  <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_rmask_q <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      pd_q         <= '0;
      rob_q        <= '0;
      cdb_q        <= '0;
`ifdef LOAD_ISSUE_ROUND_ROBIN_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dmem_read_q  <= dmem_read_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_rmask_q <= dmem_rmask_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      pd_q         <= pd_d;
      rob_q        <= rob_d;
      cdb_q        <= cdb_d;
`ifdef LOAD_ISSUE_ROUND_ROBIN_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign dmem_read  = dmem_read_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_rmask = dmem_rmask_q;

  // A mispredict in the broadcast cycle kills the result on the bus.
  always_comb begin
    load_cdb       = cdb_q;
    load_cdb.valid = cdb_q.valid & ~mispredict;
  end

endmodule

// File: tb/tb_load_issue_unit.sv
// Testbench for load_issue_unit: directed vector table, hand-written flush /
// reset / priority sequences, then randomized traffic against a
// transaction-level reference model.
module tb_load_issue_unit;
  import load_issue_unit_pkg::*;

  localparam int unsigned NUM  = 8;
  localparam int unsigned BITS = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                mispredict;
  load_rs_entry_t      rs [NUM];
  logic                free;
  logic [BITS-1:0]     free_idx;
  logic [31:0]         dmem_addr;
  logic [3:0]          dmem_rmask;
  logic                dmem_read;
  logic                dmem_resp;
  logic [31:0]         dmem_rdata;
  cdb_t                load_cdb;

  int n_total = 0;
  int n_pass  = 0;

  load_issue_unit #(.NUM_LOAD_RS(NUM), .LOAD_RS_BITS(BITS)) dut (
    .clk(clk), .rst(rst), .mispredict(mispredict), .rs_entries(rs),
    .free(free), .free_idx(free_idx), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_read(dmem_read), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .load_cdb(load_cdb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_rs();
    for (int i = 0; i < int'(NUM); i++) rs[i] = '0;
  endtask

  // Reference: bytes selected by width, then numeric sign/zero extension.
  function automatic logic [31:0] ref_align(input logic [2:0] f3, input int unsigned off,
                                            input logic [31:0] rdata);
    longint      v;
    int unsigned w;
    w = int'(rdata >> (8 * off));
    case (f3)
      F3_LB:   begin v = w % 256;   if (v >= 128)   v = v - 256;   end
      F3_LBU:  v = w % 256;
      F3_LH:   begin v = w % 65536; if (v >= 32768) v = v - 65536; end
      F3_LHU:  v = w % 65536;
      default: v = longint'(rdata);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input int unsigned off);
    int unsigned bytes;
    case (f3)
      F3_LB, F3_LBU: bytes = 1;
      F3_LH, F3_LHU: bytes = 2;
      default:       bytes = 4;
    endcase
    return 4'(((1 << bytes) - 1) << off);
  endfunction

  // From the first REQ cycle: wait lat cycles, respond, check the broadcast.
  // Returns just after the edge that starts cycle R+2.
  task automatic finish_load(input int lat, input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic [3:0] exp_mask, input bit exp_valid,
                             input logic [31:0] exp_val, input logic [PHYS_REG_BITS-1:0] exp_pd,
                             input logic [ROB_BITS-1:0] exp_rob, input string tag);
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
      end
      settle();
      chk({tag, "_read"}, 32'(dmem_read), 32'd1);
      chk({tag, "_addr"}, dmem_addr, exp_addr);
      chk({tag, "_mask"}, 32'(dmem_rmask), 32'(exp_mask));
      chk({tag, "_req_nofree"}, 32'(free), 32'd0);
      chk({tag, "_req_novalid"}, 32'(load_cdb.valid), 32'd0);
      next_cycle();
    end
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom();
    settle();
    chk({tag, "_cdb_valid"}, 32'(load_cdb.valid), 32'(exp_valid));
    if (exp_valid) begin
      chk({tag, "_cdb_value"}, load_cdb.value, exp_val);
      chk({tag, "_cdb_pd"}, 32'(load_cdb.pd), 32'(exp_pd));
      chk({tag, "_cdb_rob"}, 32'(load_cdb.rob_num), 32'(exp_rob));
    end
    chk({tag, "_read_drop"}, 32'(dmem_read), 32'd0);
    chk({tag, "_bcast_nofree"}, 32'(free), 32'd0);
    next_cycle();
  endtask

  task automatic issue_one(input int slot, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input int lat, input logic [3:0] exp_mask,
                           input logic [31:0] exp_val, input string tag);
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_BITS-1:0]      rob;
    pd  = PHYS_REG_BITS'(slot + 10);
    rob = ROB_BITS'(slot + 3);
    clear_rs();
    rs[slot] = '{state: RS_READY, addr: addr, funct3: f3, pd: pd, rob_num: rob};
    settle();
    chk({tag, "_free"}, 32'(free), 32'd1);
    chk({tag, "_free_idx"}, 32'(free_idx), 32'(slot));
    next_cycle();
    rs[slot].state = RS_EMPTY;
    finish_load(lat, rdata, {addr[31:2], 2'b00}, exp_mask, 1'b1, exp_val, pd, rob, tag);
    settle();
    chk({tag, "_valid_once"}, 32'(load_cdb.valid), 32'd0);
    next_cycle();
  endtask

  typedef struct {
    int          slot;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  mask;
    logic [31:0] val;
  } vec_t;

  vec_t vecs [8];

  task automatic random_phase(input int cycles);
    bit                       inflight, flushed, cool, bcast_ok, clr_pending, found, e_free, e_valid;
    int unsigned              rr_m, sel, idx, clr_idx, mem_wait, s, fsel;
    logic [31:0]              t_addr, e_val, a;
    logic [2:0]               t_f3, f;
    logic [PHYS_REG_BITS-1:0] t_pd, e_pd;
    logic [ROB_BITS-1:0]      t_rob, e_rob;
    inflight = 0; flushed = 0; cool = 0; bcast_ok = 0; clr_pending = 0;
    rr_m = 0; mem_wait = 0; clr_idx = 0; sel = 0;
    t_addr = '0; t_f3 = '0; t_pd = '0; t_rob = '0; e_val = '0; e_pd = '0; e_rob = '0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (clr_pending) rs[clr_idx].state = RS_EMPTY;
      clr_pending = 0;
      // Station side: new entries arrive, waiting ones become ready.
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, NUM - 1);
        if (rs[s].state == RS_EMPTY) begin
          fsel = $urandom_range(0, 4);
          case (fsel)
            0: f = F3_LB;
            1: f = F3_LBU;
            2: f = F3_LH;
            3: f = F3_LHU;
            default: f = F3_LW;
          endcase
          a = $urandom();
          if (f == F3_LW) a[1:0] = 2'b00;
          else if (f == F3_LH || f == F3_LHU) a[0] = 1'b0;
          rs[s] = '{state: ($urandom_range(0, 2) == 0) ? RS_WAIT : RS_READY, addr: a,
                    funct3: f, pd: PHYS_REG_BITS'($urandom()), rob_num: ROB_BITS'($urandom())};
        end
      end
      s = $urandom_range(0, NUM - 1);
      if (rs[s].state == RS_WAIT && $urandom_range(0, 1) == 0) rs[s].state = RS_READY;
      mispredict = ($urandom_range(0, 11) == 0);
      dmem_resp  = 1'b0;
      if (inflight) begin
        if (mem_wait == 0) begin
          dmem_resp  = 1'b1;
          dmem_rdata = $urandom();
        end else begin
          mem_wait--;
        end
      end

      found = 0;
      for (int k = 0; k < int'(NUM); k++) begin
        idx = (rr_m + k) % NUM;
        if (!found && rs[idx].state == RS_READY) begin
          found = 1;
          sel   = idx;
        end
      end
      e_free  = !inflight && !cool && !mispredict && found;
      e_valid = cool && bcast_ok && !mispredict;

      settle();
      chk("rnd_free", 32'(free), 32'(e_free));
      if (e_free) chk("rnd_free_idx", 32'(free_idx), sel);
      chk("rnd_cdb_valid", 32'(load_cdb.valid), 32'(e_valid));
      if (e_valid) begin
        chk("rnd_cdb_value", load_cdb.value, e_val);
        chk("rnd_cdb_pd", 32'(load_cdb.pd), 32'(e_pd));
        chk("rnd_cdb_rob", 32'(load_cdb.rob_num), 32'(e_rob));
      end
      chk("rnd_read", 32'(dmem_read), 32'(inflight));
      if (inflight) begin
        chk("rnd_addr", dmem_addr, {t_addr[31:2], 2'b00});
        chk("rnd_mask", 32'(dmem_rmask), 32'(ref_mask(t_f3, 32'(t_addr[1:0]))));
      end

      // Advance the transaction model.
      cool_update: begin
        bit cool_n;
        cool_n = inflight && dmem_resp && !flushed;
        if (cool_n) begin
          bcast_ok = !mispredict;
          e_val    = ref_align(t_f3, 32'(t_addr[1:0]), dmem_rdata);
          e_pd     = t_pd;
          e_rob    = t_rob;
        end
        if (inflight) begin
          if (dmem_resp) inflight = 0;
          else if (mispredict) flushed = 1;
        end
        cool = cool_n;
      end
      if (e_free) begin
        t_addr      = rs[sel].addr;
        t_f3        = rs[sel].funct3;
        t_pd        = rs[sel].pd;
        t_rob       = rs[sel].rob_num;
        inflight    = 1;
        flushed     = 0;
        mem_wait    = $urandom_range(0, 3);
        clr_pending = 1;
        clr_idx     = sel;
`ifdef LOAD_ISSUE_ROUND_ROBIN_EN
        rr_m        = (sel + 1) % NUM;
`endif
      end
      next_cycle();
    end
    mispredict = 1'b0;
    dmem_resp  = 1'b0;
  endtask

  initial begin
    int first, second;
    vecs[0] = '{2, 32'h0000_1004, F3_LW,  32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF};
    vecs[1] = '{0, 32'h0000_2003, F3_LB,  32'h80FF_FFFF, 0, 4'b1000, 32'hFFFF_FF80};
    vecs[2] = '{7, 32'h0000_2003, F3_LBU, 32'h80FF_FFFF, 2, 4'b1000, 32'h0000_0080};
    vecs[3] = '{4, 32'h0000_2002, F3_LHU, 32'h8001_1234, 1, 4'b1100, 32'h0000_8001};
    vecs[4] = '{3, 32'h0000_2002, F3_LH,  32'h8001_1234, 3, 4'b1100, 32'hFFFF_8001};
    vecs[5] = '{6, 32'h0000_3000, F3_LB,  32'h1234_567F, 0, 4'b0001, 32'h0000_007F};
    vecs[6] = '{1, 32'h0000_4000, F3_LH,  32'h1234_ABCD, 2, 4'b0011, 32'hFFFF_ABCD};
    vecs[7] = '{5, 32'h0000_5001, F3_LBU, 32'h0000_AB00, 1, 4'b0010, 32'h0000_00AB};

    rst = 1'b1; mispredict = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
    clear_rs();
    repeat (2) next_cycle();
    settle();
    chk("rst_free", 32'(free), 32'd0);
    chk("rst_free_idx", 32'(free_idx), 32'd0);
    chk("rst_read", 32'(dmem_read), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_mask", 32'(dmem_rmask), 32'd0);
    chk("rst_cdb", 32'(load_cdb), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Nothing ready: no release, no request.
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("idle_free", 32'(free), 32'd0);
      chk("idle_read", 32'(dmem_read), 32'd0);
      next_cycle();
    end

    // Entry 2 first (moves the round-robin pointer to 3), then 1 and 5 together.
    issue_one(2, 32'h0000_1004, F3_LW, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF, "prio_seed");
`ifdef LOAD_ISSUE_ROUND_ROBIN_EN
    first = 5; second = 1;
`else
    first = 1; second = 5;
`endif
    clear_rs();
    rs[1] = '{state: RS_READY, addr: 32'h0000_0100, funct3: F3_LW, pd: 6'd21, rob_num: 5'd11};
    rs[5] = '{state: RS_READY, addr: 32'h0000_0504, funct3: F3_LW, pd: 6'd25, rob_num: 5'd15};
    settle();
    chk("prio_first_free", 32'(free), 32'd1);
    chk("prio_first_idx", 32'(free_idx), 32'(first));
    next_cycle();
    rs[first].state = RS_EMPTY;
    finish_load(0, 32'h1111_2222, rs[first].addr, 4'b1111, 1'b1, 32'h1111_2222,
                rs[first].pd, rs[first].rob_num, "prio_first");
    settle();
    chk("prio_second_free", 32'(free), 32'd1);
    chk("prio_second_idx", 32'(free_idx), 32'(second));
    next_cycle();
    rs[second].state = RS_EMPTY;
    finish_load(1, 32'h3333_4444, rs[second].addr, 4'b1111, 1'b1, 32'h3333_4444,
                rs[second].pd, rs[second].rob_num, "prio_second");
    next_cycle();

    for (int i = 0; i < 8; i++)
      issue_one(vecs[i].slot, vecs[i].addr, vecs[i].f3, vecs[i].rdata, vecs[i].lat,
                vecs[i].mask, vecs[i].val, $sformatf("vec%0d", i));

    // Flush while the read is outstanding, memory latency 4.
    clear_rs();
    rs[3] = '{state: RS_READY, addr: 32'h0000_3330, funct3: F3_LW, pd: 6'd7, rob_num: 5'd2};
    settle();
    chk("mp_free", 32'(free), 32'd1);
    chk("mp_idx", 32'(free_idx), 32'd3);
    next_cycle();
    rs[3].state = RS_EMPTY;
    rs[6] = '{state: RS_READY, addr: 32'h0000_6001, funct3: F3_LBU, pd: 6'd9, rob_num: 5'd4};
    mispredict = 1'b1;
    settle();
    chk("mp_read", 32'(dmem_read), 32'd1);
    chk("mp_nofree", 32'(free), 32'd0);
    next_cycle();
    mispredict = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
      end
      settle();
      chk("mp_drain_read", 32'(dmem_read), 32'd1);
      chk("mp_drain_nofree", 32'(free), 32'd0);
      chk("mp_drain_novalid", 32'(load_cdb.valid), 32'd0);
      next_cycle();
    end
    dmem_resp = 1'b0;
    settle();
    chk("mp_no_cdb", 32'(load_cdb.valid), 32'd0);
    chk("mp_read_drop", 32'(dmem_read), 32'd0);
    chk("mp_next_free", 32'(free), 32'd1);
    chk("mp_next_idx", 32'(free_idx), 32'd6);
    next_cycle();
    rs[6].state = RS_EMPTY;
    finish_load(1, 32'h0000_C300, 32'h0000_6000, 4'b0010, 1'b1, 32'h0000_00C3, 6'd9, 5'd4, "mp_next");

    // Reset arriving during the broadcast cycle.
    clear_rs();
    rs[0] = '{state: RS_READY, addr: 32'h0000_0040, funct3: F3_LW, pd: 6'd1, rob_num: 5'd1};
    settle();
    chk("rstb_free", 32'(free), 32'd1);
    next_cycle();
    rs[0].state = RS_EMPTY;
    dmem_resp   = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    settle();
    next_cycle();
    dmem_resp = 1'b0;
    rst       = 1'b1;
    settle();
    chk("rstb_valid_before", 32'(load_cdb.valid), 32'd1);
    next_cycle();
    rst = 1'b0;
    settle();
    chk("rstb_cdb", 32'(load_cdb), 32'd0);
    chk("rstb_read", 32'(dmem_read), 32'd0);
    chk("rstb_addr", dmem_addr, 32'd0);
    chk("rstb_mask", 32'(dmem_rmask), 32'd0);
    chk("rstb_free", 32'(free), 32'd0);
    chk("rstb_free_idx", 32'(free_idx), 32'd0);
    next_cycle();

    random_phase(3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
